// File: rtl/neureka_col_accumulator_pkg.sv
// rtl/neureka_col_accumulator_pkg.sv - shared types and constants for the column accumulator
//
// Contents:
//   NEUREKA_ACC_WIDTH / NEUREKA_CNT_WIDTH : default accumulator and counter widths
//   COL_ACC_IDLE/ACCUM/OUT                : state encodings
//   ctrl_col_accum_t                      : per-window control (nb_accum, is_signed)
//   flags_col_accum_t                     : status flags (busy, cnt)
package neureka_col_accumulator_pkg;

  localparam int unsigned NEUREKA_ACC_WIDTH = 32;
  localparam int unsigned NEUREKA_CNT_WIDTH = 8;

  typedef logic [1:0] col_accum_state_t;

  localparam logic [1:0] COL_ACC_IDLE  = 2'd0;
  localparam logic [1:0] COL_ACC_ACCUM = 2'd1;
  localparam logic [1:0] COL_ACC_OUT   = 2'd2;

  typedef struct packed {
    logic [NEUREKA_CNT_WIDTH-1:0] nb_accum;
    logic                         is_signed;
  } ctrl_col_accum_t;

  typedef struct packed {
    logic                         busy;
    logic [NEUREKA_CNT_WIDTH-1:0] cnt;
  } flags_col_accum_t;

endpackage

// File: rtl/cluster_clock_gating.sv
// rtl/cluster_clock_gating.sv - latch-based clock gate
//
// Ports:
//   clk_i     : free-running clock
//   en_i      : functional enable, captured while clk_i is low
//   test_en_i : forces the clock on
//   clk_o     : gated clock
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Transparent while the clock is low so the enable cannot glitch clk_o.
  always_latch begin
    if (!clk_i) begin
      en_latch <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/neureka_col_accumulator.sv
// rtl/neureka_col_accumulator.sv - per-column accumulator of scaled binconv partial results
//
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   enable_i, clear_i             : local enable (low freezes), synchronous clear
//   pres_valid_i/data_i/ready_o   : incoming partial-result stream
//   nb_accum_i                    : beats per window (0 treated as 1), latched on first beat
//   signed_i                      : per-beat sign (1) or zero (0) extension
//   acc_valid_o/data_o/ready_i    : accumulated result stream
//   busy_o, cnt_o                 : not-idle flag, beats accepted in current window
module neureka_col_accumulator
  import neureka_col_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned ACC_WIDTH = NEUREKA_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 pres_valid_i,
  input  logic [IN_WIDTH-1:0]  pres_data_i,
  output logic                 pres_ready_o,
  input  logic [CNT_WIDTH-1:0] nb_accum_i,
  input  logic                 signed_i,
  output logic                 acc_valid_o,
  output logic [ACC_WIDTH-1:0] acc_data_o,
  input  logic                 acc_ready_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic clk_gated;

  cluster_clock_gating i_clk_gate (
    .clk_i     ( clk_i               ),
    .en_i      ( enable_i | clear_i  ),
    .test_en_i ( 1'b0                ),
    .clk_o     ( clk_gated           )
  );

  col_accum_state_t     state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] len_q;

  logic [ACC_WIDTH-1:0] beat_ext;
  logic [CNT_WIDTH-1:0] len_new;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 beat_acc;
  logic                 start_win;

  assign beat_ext = signed_i ? ACC_WIDTH'($signed(pres_data_i)) : ACC_WIDTH'(pres_data_i);
  assign len_new  = (nb_accum_i == '0) ? CNT_WIDTH'(1) : nb_accum_i;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  // Ready is qualified with rst_ni so every output reads 0 while reset is held.
  // In OUT the next window may only start when the current result drains.
  always_comb begin
    pres_ready_o = 1'b0;
    if (rst_ni && enable_i) begin
      if (state_q == COL_ACC_OUT) begin
        pres_ready_o = acc_ready_i;
      end else begin
        pres_ready_o = 1'b1;
      end
    end
  end

  assign beat_acc  = pres_valid_i & pres_ready_o;
  assign start_win = beat_acc & ((state_q == COL_ACC_IDLE) | (state_q == COL_ACC_OUT));

  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COL_ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else if (clear_i) begin
      state_q <= COL_ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else if (enable_i) begin
      if (start_win) begin
        acc_q   <= beat_ext;
        cnt_q   <= CNT_WIDTH'(1);
        len_q   <= len_new;
        state_q <= (len_new == CNT_WIDTH'(1)) ? COL_ACC_OUT : COL_ACC_ACCUM;
      end else begin
        case (state_q)
          COL_ACC_ACCUM: begin
            if (beat_acc) begin
              acc_q <= acc_q + beat_ext;
              cnt_q <= cnt_inc;
              if (cnt_inc == len_q) begin
                state_q <= COL_ACC_OUT;
              end
            end
          end
          COL_ACC_OUT: begin
            // Result drained with no new beat behind it.
            if (acc_ready_i) begin
              state_q <= COL_ACC_IDLE;
              cnt_q   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign acc_valid_o = (state_q == COL_ACC_OUT);
  assign acc_data_o  = (state_q == COL_ACC_OUT) ? acc_q : '0;
  assign busy_o      = (state_q != COL_ACC_IDLE);
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_neureka_col_accumulator.sv
// tb/tb_neureka_col_accumulator.sv - self-checking bench for neureka_col_accumulator
module tb_neureka_col_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, clear, pvalid, sgn, acc_ready;
  logic [23:0] pdata;
  logic [7:0]  nb;

  logic        pready_a, avalid_a, busy_a;
  logic [31:0] adata_a;
  logic [7:0]  cnt_a;
  logic        pready_b, avalid_b, busy_b;
  logic [23:0] adata_b;
  logic [7:0]  cnt_b;

  neureka_col_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .pres_valid_i(pvalid), .pres_data_i(pdata), .pres_ready_o(pready_a),
    .nb_accum_i(nb), .signed_i(sgn),
    .acc_valid_o(avalid_a), .acc_data_o(adata_a), .acc_ready_i(acc_ready),
    .busy_o(busy_a), .cnt_o(cnt_a)
  );

  neureka_col_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .pres_valid_i(pvalid), .pres_data_i(pdata), .pres_ready_o(pready_b),
    .nb_accum_i(nb), .signed_i(sgn),
    .acc_valid_o(avalid_b), .acc_data_o(adata_b), .acc_ready_i(acc_ready),
    .busy_o(busy_b), .cnt_o(cnt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level model: a window collects beats into an unbounded sum; once
  // complete, its result waits in a one-entry output slot until drained.
  bit     m_in_win, m_pend, m_acc;
  int     m_len, m_cnt;
  longint m_sum, m_out;

  task automatic model_reset();
    m_in_win = 0; m_pend = 0; m_len = 0; m_cnt = 0; m_sum = 0; m_out = 0;
  endtask

  function automatic bit m_ready();
    return rst_n && enable && (!m_pend || acc_ready);
  endfunction

  function automatic longint ext_beat();
    if (sgn) return longint'($signed(pdata));
    return longint'(pdata);
  endfunction

  always @(posedge clk) begin
    bit take, drain;
    m_acc = 0;
    if (!rst_n || clear) begin
      model_reset();
    end else if (enable) begin
      take  = pvalid && m_ready();
      drain = m_pend && acc_ready;
      m_acc = take;
      if (drain) begin
        m_pend = 0;
        m_cnt  = 0;
      end
      if (take) begin
        if (!m_in_win) begin
          m_in_win = 1;
          m_len    = (nb == 0) ? 1 : int'(nb);
          m_cnt    = 0;
          m_sum    = 0;
        end
        m_sum += ext_beat();
        m_cnt++;
        if (m_cnt == m_len) begin
          m_in_win = 0;
          m_pend   = 1;
          m_out    = m_sum;
        end
      end
    end
  end

  always @(negedge rst_n) model_reset();

  // Per-cycle comparison, well after inputs are driven on the falling edge.
  always @(negedge clk) begin
    #2;
    chk("pres_ready_a", 64'(pready_a), 64'(m_ready()));
    chk("pres_ready_b", 64'(pready_b), 64'(m_ready()));
    chk("acc_valid_a", 64'(avalid_a), 64'(m_pend));
    chk("acc_valid_b", 64'(avalid_b), 64'(m_pend));
    chk("busy_a", 64'(busy_a), 64'(m_in_win || m_pend));
    chk("cnt_a", 64'(cnt_a), 64'(m_cnt));
    chk("cnt_b", 64'(cnt_b), 64'(m_cnt));
    if (m_pend) begin
      chk("acc_data_a", 64'(adata_a), 64'(m_out[31:0]));
      chk("acc_data_b", 64'(adata_b), 64'(m_out[23:0]));
    end
  end

  // Drives one beat (caller is on a falling edge) and returns on the falling
  // edge after it was accepted.
  task automatic push(input logic [23:0] d);
    bit got = 0;
    pvalid = 1'b1;
    pdata  = d;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        got = 1;
        break;
      end
    end
    @(negedge clk);
    pvalid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: beat 0x%0h not accepted within 32 cycles", d);
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 0; enable = 1; clear = 0; pvalid = 0; pdata = '0; nb = 8'd1; sgn = 0; acc_ready = 1;
    settle(2);
    #3;
    chk("reset_valid", 64'(avalid_a), 64'd0);
    chk("reset_ready", 64'(pready_a), 64'd0);
    chk("reset_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    rst_n = 1;
    settle(1);

    // 4-beat unsigned window
    nb = 8'd4; sgn = 0;
    push(24'd10); push(24'd20); push(24'd30); push(24'd40);
    #3;
    chk("t1_valid", 64'(avalid_a), 64'd1);
    chk("t1_sum", 64'(adata_a), 64'd100);
    settle(1);
    #3;
    chk("t1_busy_after", 64'(busy_a), 64'd0);
    @(negedge clk);

    // signed window: -1 + 5 + -2
    nb = 8'd3; sgn = 1;
    push(24'hFFFFFF); push(24'd5); push(24'hFFFFFE);
    #3;
    chk("t2_sum", 64'(adata_a), 64'h0000_0002);
    settle(2);

    // single-beat windows, back to back
    nb = 8'd1; sgn = 0;
    push(24'd7);
    #3; chk("t3_out7", 64'(adata_a), 64'd7);
    push(24'd8);
    #3; chk("t3_out8", 64'(adata_a), 64'd8);
    push(24'd9);
    #3; chk("t3_out9", 64'(adata_a), 64'd9);
    settle(2);

    // same stimulus with the consumer stalled for 3 cycles
    acc_ready = 0;
    push(24'd7);
    pvalid = 1; pdata = 24'd8;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t4_hold_data", 64'(adata_a), 64'd7);
      chk("t4_hold_ready", 64'(pready_a), 64'd0);
      @(negedge clk);
    end
    acc_ready = 1;
    push(24'd8);
    #3; chk("t4_out8", 64'(adata_a), 64'd8);
    push(24'd9);
    #3; chk("t4_out9", 64'(adata_a), 64'd9);
    settle(2);

    // nb_accum = 0 acts as 1
    nb = 8'd0;
    push(24'd3);
    #3;
    chk("t5_nb0_valid", 64'(avalid_a), 64'd1);
    chk("t5_nb0_data", 64'(adata_a), 64'd3);
    settle(2);

    // wrap in the 24-bit instance, carry kept in the 32-bit one
    nb = 8'd2; sgn = 0;
    push(24'hFFFFFF); push(24'h000002);
    #3;
    chk("t5_wrap24", 64'(adata_b), 64'h00_0001);
    chk("t5_nowrap32", 64'(adata_a), 64'h0100_0001);
    settle(2);

    // clear part-way through a window
    nb = 8'd4;
    push(24'd9); push(24'd9);
    clear = 1;
    @(negedge clk);
    clear = 0;
    #3;
    chk("t6_clear_cnt", 64'(cnt_a), 64'd0);
    chk("t6_clear_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    push(24'd1); push(24'd1); push(24'd1); push(24'd1);
    #3; chk("t6_sum4", 64'(adata_a), 64'd4);
    settle(2);

    // enable low mid-window freezes everything
    push(24'd1); push(24'd1);
    enable = 0; pvalid = 1; pdata = 24'd100;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t7_frozen_ready", 64'(pready_a), 64'd0);
      chk("t7_frozen_cnt", 64'(cnt_a), 64'd2);
      @(negedge clk);
    end
    enable = 1; pvalid = 0;
    push(24'd1); push(24'd1);
    #3; chk("t7_sum4", 64'(adata_a), 64'd4);
    settle(2);

    // asynchronous reset while a result is pending
    nb = 8'd1; acc_ready = 0;
    push(24'd55);
    #3;
    rst_n = 0;
    #1;
    chk("t8_rst_valid", 64'(avalid_a), 64'd0);
    chk("t8_rst_data", 64'(adata_a), 64'd0);
    chk("t8_rst_busy", 64'(busy_a), 64'd0);
    chk("t8_rst_cnt", 64'(cnt_a), 64'd0);
    chk("t8_rst_ready", 64'(pready_a), 64'd0);
    @(negedge clk);
    rst_n = 1; acc_ready = 1; nb = 8'd2;
    @(negedge clk);
    push(24'd1); push(24'd2);
    #3; chk("t8_after_rst", 64'(adata_a), 64'd3);
    settle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
